// File: rtl/uart_input_ctrl.sv
// uart_input_ctrl
//   Host-driven replacement for the VIO probes of the lab top. An 8N1 UART
//   receiver feeds a small byte-command parser that drives the virtual
//   switches and buttons of the wrapped design.
//
//   Commands (one or more bytes):
//     'S' hi lo : sw <= {hi, lo}
//     'B' mask  : btn <= mask[4:0] for BTN_PULSE_CYCLES cycles (mask[7:5] must be 0)
//     'R'       : sw <= 0, btn <= 0, any running button hold cancelled
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx         in   UART serial input, idle high, asynchronous to clk
//   sw         out  [15:0] virtual switches
//   btn        out  [4:0]  virtual buttons: [4]=L [3]=D [2]=U [1]=R [0]=C
//   byte_valid out  1-cycle pulse, byte_data holds a correctly framed byte
//   byte_data  out  [7:0]  last correctly framed byte
//   cmd_ok     out  1-cycle pulse, a command was executed
//   cmd_err    out  1-cycle pulse, unknown opcode or illegal operand
//   frame_err  out  1-cycle pulse, stop bit sampled low, byte dropped
module uart_input_ctrl #(
  parameter int CLK_FREQ         = 100_000_000,
  parameter int BAUD             = 115200,
  parameter int BTN_PULSE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] sw,
  output logic [4:0]  btn,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic        frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BCW          = $clog2(CLKS_PER_BIT + 1);
  localparam int HCW          = $clog2(BTN_PULSE_CYCLES + 1);

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(BTN_PULSE_CYCLES);
  localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_SW_HI = 2'd1;
  localparam logic [1:0] P_SW_LO = 2'd2;
  localparam logic [1:0] P_BTN   = 2'd3;

  localparam logic [7:0] OP_SW    = 8'h53;
  localparam logic [7:0] OP_BTN   = 8'h42;
  localparam logic [7:0] OP_RESET = 8'h52;

  logic           rx_p0;
  logic           rx_p1;
  logic           rx_p2;
  logic [1:0]     rx_state;
  logic [BCW-1:0] bit_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     rx_shift;
  logic [1:0]     p_state;
  logic [7:0]     sw_hi;
  logic [HCW-1:0] hold_cnt;

  // ---- stage: rx synchronizer (p0,p1) and one-cycle history (p2) ----
  // rx_p2 lets the idle state require a high-to-low transition, so a line
  // held low (break) after a bad stop bit does not start another frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // ---- stage: bit-level receive FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      byte_data  <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (rx_p2 && !rx_p1) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Re-check the start bit in its middle; a high line means a glitch.
          if (bit_cnt == HALF_LAST) begin
            bit_cnt  <= '0;
            rx_state <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_p1) begin
              byte_valid <= 1'b1;
              byte_data  <= rx_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && bit_cnt == BIT_LAST) begin
      rx_shift <= {rx_p1, rx_shift[7:1]};
    end
  end

  // ---- stage: command parser and button hold timer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state  <= P_IDLE;
      sw       <= '0;
      btn      <= '0;
      hold_cnt <= '0;
      cmd_ok   <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;

      // Countdown first; a command completing this cycle overrides it below,
      // which restarts a running hold without a gap cycle.
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HOLD_ONE) begin
          btn <= '0;
        end
      end

      if (frame_err) begin
        p_state <= P_IDLE;
      end else if (byte_valid) begin
        case (p_state)
          P_IDLE: begin
            case (byte_data)
              OP_SW:  p_state <= P_SW_HI;
              OP_BTN: p_state <= P_BTN;
              OP_RESET: begin
                sw       <= '0;
                btn      <= '0;
                hold_cnt <= '0;
                cmd_ok   <= 1'b1;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
          P_SW_HI: p_state <= P_SW_LO;
          P_SW_LO: begin
            sw      <= {sw_hi, byte_data};
            cmd_ok  <= 1'b1;
            p_state <= P_IDLE;
          end
          P_BTN: begin
            if (byte_data[7:5] != 3'b000) begin
              cmd_err <= 1'b1;
            end else begin
              btn      <= byte_data[4:0];
              hold_cnt <= HOLD_LOAD;
              cmd_ok   <= 1'b1;
            end
            p_state <= P_IDLE;
          end
          default: p_state <= P_IDLE;
        endcase
      end
    end
  end

  // High switch byte is only consumed after the low byte arrives.
  always_ff @(posedge clk) begin
    if (byte_valid && p_state == P_SW_HI) begin
      sw_hi <= byte_data;
    end
  end

endmodule
